// File: rtl/muldiv_pkg.sv
// Shared encodings and op-class helpers for the HI/LO multiply/divide unit.
// Optional build macro: MULDIV_DIV0_FASTPATH_EN (see hilo_muldiv_unit).
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MADD  = 3'd2,
        OP_MADDU = 3'd3,
        OP_MSUB  = 3'd4,
        OP_MSUBU = 3'd5,
        OP_DIV   = 3'd6,
        OP_DIVU  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    function automatic logic is_signed(input op_e o);
        return ~o[0];
    endfunction

    function automatic logic is_fused(input op_e o);
        return (o[2:1] == 2'b01) || (o[2:1] == 2'b10);
    endfunction

    function automatic logic is_sub(input op_e o);
        return o[2:1] == 2'b10;
    endfunction

    function automatic logic is_div(input op_e o);
        return o[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    assign val_o = en_i ? -val_i : val_i;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning HI/LO; radix-2^MUL_STEP multiplier, restoring divider.
// Define MULDIV_DIV0_FASTPATH_EN to skip divider iterations when the divisor is zero.
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             abort,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             hi_write,
    input  logic             lo_write,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int W  = WIDTH;
    localparam int S  = MUL_STEP;
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0] MUL_LAST = CW'(W / S - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic [W-1:0]   a_q, a_d;
    logic [2*W-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    op_e          op_in;
    logic         sgn_in;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;

    assign op_in  = op_e'(op);
    assign sgn_in = is_signed(op_in);

    muldiv_negate #(.W(W)) u_abs_a (
        .en_i  (sgn_in & A[W-1]),
        .val_i (A),
        .val_o (abs_a)
    );

    muldiv_negate #(.W(W)) u_abs_b (
        .en_i  (sgn_in & B[W-1]),
        .val_i (B),
        .val_o (abs_b)
    );

    // p_q = {partial, multiplier}: add a_q * low digit, then shift right by S
    logic [W+S-1:0] mprod;
    logic [W+S-1:0] msum;
    logic [2*W-1:0] mul_next;

    assign mprod    = {{S{1'b0}}, a_q} * {{W{1'b0}}, p_q[S-1:0]};
    assign msum     = {{S{1'b0}}, p_q[2*W-1:W]} + mprod;
    assign mul_next = {msum, p_q[W-1:S]};

    // p_q = {remainder, dividend/quotient}; one restoring step per cycle
    logic [W:0]     dshift;
    logic [W:0]     dtrial;
    logic [2*W-1:0] div_next;

    assign dshift   = {p_q[2*W-1:W], p_q[W-1]};
    assign dtrial   = dshift - {1'b0, a_q};
    assign div_next = dtrial[W]
                    ? {dshift[W-1:0], p_q[W-2:0], 1'b0}
                    : {dtrial[W-1:0], p_q[W-2:0], 1'b1};

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    muldiv_negate #(.W(2 * W)) u_fix_prod (
        .en_i  (neg_q),
        .val_i (p_q),
        .val_o (prod_fix)
    );

    muldiv_negate #(.W(W)) u_fix_quo (
        .en_i  (neg_q),
        .val_i (p_q[W-1:0]),
        .val_o (quo_fix)
    );

    muldiv_negate #(.W(W)) u_fix_rem (
        .en_i  (rneg_q),
        .val_i (p_q[2*W-1:W]),
        .val_o (rem_fix)
    );

    logic [2*W-1:0] hilo;
    logic [2*W-1:0] fused_res;
    logic [2*W-1:0] mul_res;
    logic [W-1:0]   fix_hi;
    logic [W-1:0]   fix_lo;

    assign hilo      = {hi_q, lo_q};
    assign fused_res = is_sub(op_q) ? hilo - prod_fix : hilo + prod_fix;
    assign mul_res   = is_fused(op_q) ? fused_res : prod_fix;
    assign fix_hi    = is_div(op_q) ? rem_fix : mul_res[2*W-1:W];
    assign fix_lo    = is_div(op_q) ? quo_fix : mul_res[W-1:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        a_d     = a_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    op_d   = op_in;
                    neg_d  = sgn_in & (A[W-1] ^ B[W-1]);
                    rneg_d = sgn_in & A[W-1];
                    if (is_div(op_in)) begin
                        a_d     = abs_b;
                        p_d     = {{W{1'b0}}, abs_a};
                        cnt_d   = DIV_LAST;
                        state_d = ST_DIV;
`ifdef MULDIV_DIV0_FASTPATH_EN
                        if (B == '0) begin
                            p_d     = {abs_a, {W{1'b1}}};
                            state_d = ST_FIX;
                        end
`endif
                    end else begin
                        a_d     = abs_a;
                        p_d     = {{W{1'b0}}, abs_b};
                        cnt_d   = MUL_LAST;
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                p_d   = mul_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                p_d   = div_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        // direct MTHI/MTLO is the younger instruction and wins over FIX
        if (hi_write) begin
            hi_d = hi_in;
        end
        if (lo_write) begin
            lo_d = lo_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            a_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            a_q     <= a_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (WIDTH=32, MUL_STEP=4).
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        abort;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        hi_write;
    logic        lo_write;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;
    int lat;
    bit allbusy;
    bit seen;

`ifdef MULDIV_DIV0_FASTPATH_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 34;
`endif

    hilo_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .abort    (abort),
        .hi_in    (hi_in),
        .lo_in    (lo_in),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .busy     (busy),
        .done     (done),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clock);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int l, output bit ab);
        l  = 1;
        ab = 1'b1;
        while (done !== 1'b1 && l < 100) begin
            if (busy !== 1'b1) ab = 1'b0;
            step();
            l++;
        end
    endtask

    task automatic mthlo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clock);
        hi_in    = h;
        lo_in    = l;
        hi_write = 1'b1;
        lo_write = 1'b1;
        step();
        hi_write = 1'b0;
        lo_write = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        A        = '0;
        B        = '0;
        abort    = 1'b0;
        hi_in    = '0;
        lo_in    = '0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step();

        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_hi", 64'(hi_out), 64'h0);
        check("rst_lo", 64'(lo_out), 64'h0);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done(lat, allbusy);
        check("mult_lat", 64'(lat), 64'd10);
        check("mult_busy", 64'(allbusy), 64'd1);
        check("mult_busy_done", 64'(busy), 64'd0);
        check("mult_res", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);

        issue(OP_MULT, 32'h80000000, 32'd2);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_done_drop", 64'(done), 64'd0);
        wait_done(lat, allbusy);
        check("b2b_lat", 64'(lat), 64'd10);
        check("b2b_res", {hi_out, lo_out}, 64'hFFFFFFFF_00000000);

        mthlo(32'h0, 32'hFFFFFFFF);
        check("mthlo", {hi_out, lo_out}, 64'h00000000_FFFFFFFF);
        issue(OP_MADDU, 32'd1, 32'd1);
        wait_done(lat, allbusy);
        check("maddu_res", {hi_out, lo_out}, 64'h00000001_00000000);
        issue(OP_MSUB, 32'd1, 32'd1);
        wait_done(lat, allbusy);
        check("msub_lat", 64'(lat), 64'd10);
        check("msub_res", {hi_out, lo_out}, 64'h00000000_FFFFFFFF);
        issue(OP_MADD, 32'hFFFFFFFE, 32'd3);
        wait_done(lat, allbusy);
        check("madd_neg", {hi_out, lo_out}, 64'h00000000_FFFFFFF9);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, allbusy);
        check("div_lat", 64'(lat), 64'd34);
        check("div_busy", 64'(allbusy), 64'd1);
        check("div_res", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, allbusy);
        check("divu_res", {hi_out, lo_out}, 64'h00000002_0000000E);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, allbusy);
        check("div_minneg", {hi_out, lo_out}, 64'h00000000_80000000);

        issue(OP_DIVU, 32'd5, 32'd0);
        wait_done(lat, allbusy);
        check("divu0_lat", 64'(lat), 64'(DIV0_LAT));
        check("divu0_res", {hi_out, lo_out}, 64'h00000005_FFFFFFFF);
        issue(OP_DIV, 32'hFFFFFFFB, 32'd0);
        wait_done(lat, allbusy);
        check("div0_lat", 64'(lat), 64'(DIV0_LAT));
        check("div0_res", {hi_out, lo_out}, 64'hFFFFFFFB_00000001);

        mthlo(32'h11112222, 32'h33334444);
        issue(OP_MULT, 32'd3, 32'd5);
        repeat (4) step();
        abort = 1'b1;
        start = 1'b1;
        op    = OP_MULTU;
        A     = 32'd2;
        B     = 32'd3;
        step();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'h11112222_33334444);
        step();
        start = 1'b0;
        check("abort_restart", 64'(busy), 64'd1);
        wait_done(lat, allbusy);
        check("restart_lat", 64'(lat), 64'd10);
        check("restart_res", {hi_out, lo_out}, 64'h00000000_00000006);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) step();
        start = 1'b1;
        op    = OP_DIVU;
        A     = 32'd9;
        B     = 32'd3;
        step();
        start = 1'b0;
        repeat (5) step();
        check("fix_busy", 64'(busy), 64'd1);
        hi_in    = 32'hA5A5A5A5;
        hi_write = 1'b1;
        step();
        hi_write = 1'b0;
        check("fix_done", 64'(done), 64'd1);
        check("fix_wr_res", {hi_out, lo_out}, 64'hA5A5A5A5_00000001);
        step();
        check("ign_busy", 64'(busy), 64'd0);
        check("ign_done", 64'(done), 64'd0);

        issue(OP_MULT, 32'd9, 32'd9);
        repeat (2) step();
        @(negedge clock);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi_out, lo_out}, 64'h0);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        check("midrst_nodone", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
